// File: rtl/cpu_pipeline_pkg.sv
// Shared definitions for the UART GCD demo: baud divider, controller and
// receiver state encodings, and the active-low hex font for the display.
package cpu_pipeline_pkg;

  localparam int DEF_CLK_FREQ  = 100_000_000;
  localparam int DEF_BAUD      = 9600;
  localparam int DEF_SCAN_BITS = 18;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_SEND    = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp held off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/cpu_pipeline_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect with a
// half-bit glitch recheck, mid-bit sampling and stop-bit framing check.
module cpu_pipeline_uart_rx
  import cpu_pipeline_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     r_state, w_state_next;
  logic [1:0]    r_sync;
  logic          r_rx_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx, w_fall, w_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_rx};
      r_rx_prev <= r_sync[1];
    end
  end

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_prev & ~w_rx;
  assign w_tc   = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_next = RX_START;
      RX_START: if (w_tc) w_state_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tc && (r_bit == 3'd7)) w_state_next = RX_STOP;
      RX_STOP:  if (w_tc) w_state_next = RX_IDLE;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  // Idle keeps the half-bit count preloaded so the start recheck lands mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_cnt <= HALF;
          r_bit <= '0;
        end
        RX_START: begin
          if (w_tc) r_cnt <= FULL;
          else      r_cnt <= r_cnt - 1'b1;
        end
        RX_DATA: begin
          if (w_tc) begin
            r_cnt   <= FULL;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (!w_tc) r_cnt <= r_cnt - 1'b1;
        end
        default: r_cnt <= HALF;
      endcase
    end
  end

  assign o_valid = (r_state == RX_STOP) && w_tc && w_rx;
  assign o_data  = r_shift;

endmodule

// File: rtl/cpu_pipeline.sv
// Board top for the UART GCD demo: receives two operands, reduces them by
// repeated subtraction, transmits the result and shows it on LEDs / 7-seg.
//
// state      | meaning
// WAIT_A     | waiting for first operand (pending byte first)
// WAIT_B     | waiting for second operand
// COMPUTE    | one subtract step per clock until gcd found
// SEND       | transmitting result, back to WAIT_A on tx done
module cpu_pipeline
  import cpu_pipeline_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
  parameter int SCAN_BITS    = DEF_SCAN_BITS
) (
  input  logic       clk,
  input  logic       resetk,
  input  logic       button,
  input  logic [7:0] switch,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] led,
  output logic [7:0] bcd,
  output logic [3:0] an
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TX_FULL = CW'(CLKS_PER_BIT - 1);

  ctrl_state_t    r_state, w_state_next;
  logic [1:0]     r_btn_sync;
  logic           w_rx_valid;
  logic [7:0]     w_rx_data;
  logic [7:0]     r_a, r_b, r_a_cap, r_b_cap;
  logic [7:0]     r_result, r_last_byte, r_led;
  logic           r_pend_valid;
  logic [7:0]     r_pend_data;
  logic           w_load_a, w_load_b, w_gcd_done, w_tx_load;
  logic           w_pend_set, w_pend_clr;
  logic [7:0]     w_in_byte, w_gcd_value;
  logic           r_tx_busy, r_tx_line;
  logic [CW-1:0]  r_tx_cnt;
  logic [3:0]     r_tx_bit;
  logic [9:0]     r_tx_frame;
  logic           w_tx_tc, w_tx_done;
  logic [SCAN_BITS-1:0] r_scan;
  logic [1:0]     w_digit_sel;
  logic [3:0]     w_nibble;
  logic           w_unused_sw;

  assign w_unused_sw = ^switch[6:0];

  cpu_pipeline_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk    (clk),
    .rst    (resetk),
    .i_rx   (RX),
    .o_valid(w_rx_valid),
    .o_data (w_rx_data)
  );

  always_ff @(posedge clk or posedge resetk) begin
    if (resetk) r_btn_sync <= 2'b00;
    else        r_btn_sync <= {r_btn_sync[0], button};
  end

  always_ff @(posedge clk or posedge resetk) begin
    if (resetk) r_state <= ST_WAIT_A;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_A:  if (r_pend_valid || w_rx_valid) w_state_next = ST_WAIT_B;
      ST_WAIT_B:  if (r_pend_valid || w_rx_valid) w_state_next = ST_COMPUTE;
      ST_COMPUTE: if (w_gcd_done) w_state_next = ST_SEND;
      ST_SEND:    if (w_tx_done) w_state_next = ST_WAIT_A;
      default:    w_state_next = ST_WAIT_A;
    endcase
  end

  always_comb begin
    w_load_a   = 1'b0;
    w_load_b   = 1'b0;
    w_gcd_done = 1'b0;
    w_tx_load  = 1'b0;
    case (r_state)
      ST_WAIT_A:  w_load_a   = r_pend_valid | w_rx_valid;
      ST_WAIT_B:  w_load_b   = r_pend_valid | w_rx_valid;
      ST_COMPUTE: w_gcd_done = (r_b == 8'd0) || (r_a == 8'd0) || (r_a == r_b);
      ST_SEND:    w_tx_load  = ~r_tx_busy;
      default:    ;
    endcase
  end

  // A stored byte is always older than one arriving on the same cycle.
  assign w_in_byte   = r_pend_valid ? r_pend_data : w_rx_data;
  assign w_gcd_value = (r_a == 8'd0) ? r_b : r_a;
  assign w_pend_set  = w_rx_valid &&
                       ((r_state == ST_COMPUTE) || (r_state == ST_SEND) || r_pend_valid);
  assign w_pend_clr  = r_pend_valid && (w_load_a || w_load_b);

  always_ff @(posedge clk or posedge resetk) begin
    if (resetk) begin
      r_a          <= '0;
      r_b          <= '0;
      r_a_cap      <= '0;
      r_b_cap      <= '0;
      r_result     <= '0;
      r_last_byte  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_led        <= '0;
    end else begin
      if (w_load_a) begin
        r_a     <= w_in_byte;
        r_a_cap <= w_in_byte;
      end
      if (w_load_b) begin
        r_b     <= w_in_byte;
        r_b_cap <= w_in_byte;
      end
      if (r_state == ST_COMPUTE) begin
        if (w_gcd_done)     r_result <= w_gcd_value;
        else if (r_a > r_b) r_a      <= r_a - r_b;
        else                r_b      <= r_b - r_a;
      end
      if (w_pend_set) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= w_rx_data;
      end else if (w_pend_clr) begin
        r_pend_valid <= 1'b0;
      end
      if (w_rx_valid) r_last_byte <= w_rx_data;
      r_led <= switch[7] ? r_last_byte : r_result;
    end
  end

  assign w_tx_tc   = (r_tx_cnt == '0);
  assign w_tx_done = r_tx_busy && w_tx_tc && (r_tx_bit == 4'd9);

  // Bit index 0 is the start bit; index 9 the stop bit.
  always_ff @(posedge clk or posedge resetk) begin
    if (resetk) begin
      r_tx_busy  <= 1'b0;
      r_tx_line  <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_frame <= '1;
    end else if (w_tx_load) begin
      r_tx_busy  <= 1'b1;
      r_tx_line  <= 1'b0;
      r_tx_frame <= {1'b1, r_result, 1'b0};
      r_tx_cnt   <= TX_FULL;
      r_tx_bit   <= '0;
    end else if (r_tx_busy) begin
      if (w_tx_tc) begin
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx_bit  <= r_tx_bit + 4'd1;
          r_tx_line <= r_tx_frame[r_tx_bit + 4'd1];
          r_tx_cnt  <= TX_FULL;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - 1'b1;
      end
    end
  end

  assign TX  = r_tx_line;
  assign led = r_led;

  always_ff @(posedge clk or posedge resetk) begin
    if (resetk) r_scan <= '0;
    else        r_scan <= r_scan + 1'b1;
  end

  assign w_digit_sel = r_scan[SCAN_BITS-1 -: 2];

  always_comb begin
    w_nibble = 4'h0;
    case (w_digit_sel)
      2'd0: w_nibble = r_btn_sync[1] ? r_b_cap[3:0] : r_last_byte[3:0];
      2'd1: w_nibble = r_btn_sync[1] ? r_b_cap[7:4] : r_last_byte[7:4];
      2'd2: w_nibble = r_btn_sync[1] ? r_a_cap[3:0] : r_result[3:0];
      2'd3: w_nibble = r_btn_sync[1] ? r_a_cap[7:4] : r_result[7:4];
      default: w_nibble = 4'h0;
    endcase
  end

  assign an  = ~(4'b0001 << w_digit_sel);
  assign bcd = hex_to_seg(w_nibble);

endmodule

// File: tb/tb_cpu_pipeline.sv
// Directed bench for cpu_pipeline with a shortened bit period and scan counter.
module tb_cpu_pipeline;
  import cpu_pipeline_pkg::*;

  localparam int CLK_FREQ  = 160;
  localparam int BAUD      = 10;
  localparam int CPB       = 16;
  localparam int SCAN_BITS = 10;
  localparam int DIG       = 1 << (SCAN_BITS - 2);

  logic       clk = 1'b0;
  logic       resetk, button, RX, TX;
  logic [7:0] switch, led, bcd;
  logic [3:0] an;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_pipeline #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .SCAN_BITS(SCAN_BITS)
  ) dut (
    .clk   (clk),
    .resetk(resetk),
    .button(button),
    .switch(switch),
    .RX    (RX),
    .TX    (TX),
    .led   (led),
    .bcd   (bcd),
    .an    (an)
  );

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk);
  endtask

  task automatic get_tx(output logic [7:0] b, output logic ok, output int t_fall);
    int n;
    n = 0;
    ok = 1'b1;
    b = 8'h00;
    while (TX !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    t_fall = cyc;
    if (TX !== 1'b0) begin
      ok = 1'b0;
    end else begin
      repeat (CPB / 2) @(negedge clk);
      if (TX !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = TX;
      end
      repeat (CPB) @(negedge clk);
      if (TX !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_digit(input logic [3:0] pat, output logic [7:0] seg, output logic ok);
    int n;
    n = 0;
    while (an !== pat && n < 4 * DIG + 8) begin
      @(negedge clk);
      n++;
    end
    ok  = (an === pat);
    seg = bcd;
  endtask

  task automatic test_reset();
    resetk = 1'b1;
    RX     = 1'b1;
    button = 1'b0;
    switch = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b expected 1110", an); end
    checks++; if (bcd !== 8'hC0) begin errors++; $display("FAIL reset_bcd: got %h expected c0", bcd); end
    resetk = 1'b0;
    repeat (DIG) @(posedge clk);
    #1;
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL scan_an: got %b expected 1101", an); end
    checks++; if (bcd !== 8'hC0) begin errors++; $display("FAIL scan_bcd: got %h expected c0", bcd); end
  endtask

  task automatic test_gcd_basic();
    logic [7:0] got, seg;
    logic       ok;
    int         t;
    logic [3:0] pats [4];
    logic [7:0] exps [4];
    pats[0] = 4'b0111; exps[0] = 8'hA4;
    pats[1] = 4'b1011; exps[1] = 8'hB0;
    pats[2] = 4'b1101; exps[2] = 8'h88;
    pats[3] = 4'b1110; exps[3] = 8'h8E;
    fork
      begin send_byte(8'hD2, 1'b1); send_byte(8'hAF, 1'b1); end
      get_tx(got, ok, t);
    join
    checks++; if (!ok || got !== 8'h23) begin errors++; $display("FAIL gcd_d2_af_tx: got %h ok=%b expected 23", got, ok); end
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h23) begin errors++; $display("FAIL gcd_d2_af_led: got %h expected 23", led); end
    for (int i = 0; i < 4; i++) begin
      wait_digit(pats[i], seg, ok);
      checks++;
      if (!ok || seg !== exps[i]) begin
        errors++; $display("FAIL display_23af_digit%0d: got %h ok=%b expected %h", 3 - i, seg, ok, exps[i]);
      end
    end
    button = 1'b1;
    repeat (4) @(negedge clk);
    wait_digit(4'b0111, seg, ok);
    checks++; if (!ok || seg !== 8'hA1) begin errors++; $display("FAIL button_digit3: got %h expected a1", seg); end
    wait_digit(4'b1011, seg, ok);
    checks++; if (!ok || seg !== 8'hA4) begin errors++; $display("FAIL button_digit2: got %h expected a4", seg); end
    button = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2;
    logic       ok1, ok2;
    int         t1, t2;
    fork
      begin
        send_byte(8'hC8, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h30, 1'b1);
      end
      begin get_tx(g1, ok1, t1); get_tx(g2, ok2, t2); end
    join
    checks++; if (!ok1 || g1 !== 8'h02) begin errors++; $display("FAIL b2b_first_tx: got %h ok=%b expected 02", g1, ok1); end
    checks++; if (!ok2 || g2 !== 8'h06) begin errors++; $display("FAIL b2b_pending_tx: got %h ok=%b expected 06", g2, ok2); end
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h06) begin errors++; $display("FAIL b2b_led_result: got %h expected 06", led); end
    switch = 8'h80;
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h30) begin errors++; $display("FAIL b2b_led_last_byte: got %h expected 30", led); end
    switch = 8'h00;
  endtask

  task automatic test_zero_operands();
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic [7:0] ev [3];
    logic [7:0] got;
    logic       ok;
    int         t_end, t_fall;
    av[0] = 8'h00; bv[0] = 8'h05; ev[0] = 8'h05;
    av[1] = 8'h00; bv[1] = 8'h00; ev[1] = 8'h00;
    av[2] = 8'h01; bv[2] = 8'hFF; ev[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      t_end = 0;
      fork
        begin send_byte(av[i], 1'b1); send_byte(bv[i], 1'b1); t_end = cyc; end
        get_tx(got, ok, t_fall);
      join
      checks++;
      if (!ok || got !== ev[i]) begin
        errors++; $display("FAIL gcd_%h_%h: got %h ok=%b expected %h", av[i], bv[i], got, ok, ev[i]);
      end
      if (i == 2) begin
        checks++;
        if (t_fall - t_end > 260) begin
          errors++; $display("FAIL gcd_worst_latency: got %0d cycles expected <= 260", t_fall - t_end);
        end
      end
    end
  endtask

  task automatic test_framing_error();
    logic [7:0] got;
    logic       ok;
    int         t;
    switch = 8'h80;
    send_byte(8'h5A, 1'b0);
    checks++; if (dut.r_state !== ST_WAIT_A) begin errors++; $display("FAIL framing_state: got %0d expected %0d", dut.r_state, ST_WAIT_A); end
    checks++; if (led !== 8'hFF) begin errors++; $display("FAIL framing_last_byte: got %h expected ff", led); end
    switch = 8'h00;
    fork
      begin send_byte(8'h0F, 1'b1); send_byte(8'h05, 1'b1); end
      get_tx(got, ok, t);
    join
    checks++; if (!ok || got !== 8'h05) begin errors++; $display("FAIL framing_followup_tx: got %h ok=%b expected 05", got, ok); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] got;
    logic       ok;
    int         n, t;
    send_byte(8'h0C, 1'b1);
    send_byte(8'h08, 1'b1);
    n = 0;
    while (TX !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL midtx_start: got %b expected 0", TX); end
    repeat (CPB / 2) @(negedge clk);
    resetk = 1'b1;
    @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midtx_reset_tx: got %b expected 1", TX); end
    checks++; if (dut.r_state !== ST_WAIT_A) begin errors++; $display("FAIL midtx_reset_state: got %0d expected %0d", dut.r_state, ST_WAIT_A); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL midtx_reset_led: got %h expected 00", led); end
    resetk = 1'b0;
    repeat (5) @(negedge clk);
    fork
      begin send_byte(8'h1B, 1'b1); send_byte(8'h09, 1'b1); end
      get_tx(got, ok, t);
    join
    checks++; if (!ok || got !== 8'h09) begin errors++; $display("FAIL midtx_after_reset_tx: got %h ok=%b expected 09", got, ok); end
  endtask

  initial begin
    test_reset();
    test_gcd_basic();
    test_back_to_back();
    test_zero_operands();
    test_framing_error();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_pipeline.md
Name: cpu_pipeline

Overview:
- Self-contained UART-driven GCD processor with board I/O: LEDs, 8 switches, 4-digit 7-segment display and a pushbutton.
- Receives two 8-bit operands over UART at 9600 baud 8N1, computes their greatest common divisor with an iterative subtract datapath, and returns the result on TX.
- Shows the result on LEDs and the 7-segment display.
- Board top-level for the MIPS lab demo; clock is 100 MHz.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (10416), clocks per UART bit.
- SCAN_BITS, 18, width of the display scan counter; its top 2 bits select the digit.

Ports:
- clk  in  1  system clock, rising edge.
- resetk  in  1  reset; asynchronous, active-high.
- button  in  1  display select; level-sensitive; pass through a 2-flop synchronizer.
- switch  in  8  LED source select (switch[7]); switch[6:0] unused.
- RX  in  1  UART receive line, idle high; pass through a 2-flop synchronizer.
- TX  out  1  UART transmit line, idle high.
- led  out  8  switch[7]=0: last GCD result; switch[7]=1: last received byte.
- bcd  out  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}; dp always off (1).
- an  out  4  digit enables, active-low, one-hot-low.

Behaviour:
- Reset (resetk=1, asynchronous): controller in WAIT_A; result=0, last_byte=0, A=B=0, pending flag=0; TX=1; led=0; scan counter=0, so an=4'b1110 and bcd=8'hC0 ("0").
- UART RX:
  - A falling edge on the synchronized RX starts a frame.
  - Recheck the start bit at CLKS_PER_BIT/2; if RX is high there, abort (glitch).
  - Sample data at the middle of each bit, LSB first, then sample the stop bit.
  - Stop bit=0: discard the byte (framing error), no strobe.
  - Valid byte: 1-cycle rx_valid pulse with rx_data.
  - The receiver runs continuously, independent of the controller state.
- Controller FSM, states WAIT_A, WAIT_B, COMPUTE, SEND:
  - WAIT_A: on rx_valid, or a pending byte, latch A and go to WAIT_B.
  - WAIT_B: on rx_valid, latch B and go to COMPUTE.
  - COMPUTE, one step per clock:
    - If B==0: result<=A, go to SEND.
    - Else if A==0: result<=B, go to SEND.
    - Else if A>B: A<=A-B.
    - Else if B>A: B<=B-A.
    - Else (A==B): result<=A, go to SEND.
    - Worst case 256 cycles. gcd(0,0)=0.
  - SEND: load result into the transmitter; return to WAIT_A when TX reports done.
  - Bytes arriving during COMPUTE or SEND go into a 1-deep pending register; a further byte overwrites it. WAIT_A consumes a pending byte before new ones.
  - last_byte updates on every valid received byte.
- UART TX, 8N1:
  - Frame is start 0, data LSB first, stop 1, each bit CLKS_PER_BIT cycles.
  - TX goes low on the cycle after the load.
  - Done asserts at the end of the stop bit.
- led is registered and selected by switch[7].
- Display:
  - The scan counter increments every clock.
  - Digit index k = counter[SCAN_BITS-1:SCAN_BITS-2]; an[k]=0, others 1.
  - button=0: digits 3..0 = {result[7:4], result[3:0], last_byte[7:4], last_byte[3:0]}.
  - button=1: digits 3..0 = {A_latched[7:4], A_latched[3:0], B_latched[7:4], B_latched[3:0]}, i.e. the operand values at capture time.
  - Hex font, active-low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Reset asserted mid-operation aborts everything immediately: TX forced to 1, FSM to WAIT_A.

Decomposition:
- Shared package: CLKS_PER_BIT derivation, the FSM state enum, and the hex-to-7-segment function.
- Natural sub-module: uart_rx, with synchronizer, mid-bit sampler and framing check.
- The transmitter, GCD datapath and display scan stay inline in cpu_pipeline.

Test Plan:
- Reset pulse → TX=1, led=0x00, an=1110, bcd=C0; after 2^16 clocks, an=1101.
- RX bytes 0xD2 then 0xAF at 104167 ns/bit → TX frame carrying 0x23 (35); led=0x23 with switch=0; display shows "23AF".
- Second pair 0x12 then 0x30, the first starting 200 µs after the previous stop bit (overlapping the TX) → TX 0x06; led=0x06; switch[7]=1 → led=0x30.
- Operands 0x00,0x05 → result 0x05. Operands 0x00,0x00 → result 0x00. Operands 0x01,0xFF → result 0x01 within 260 cycles.
- Frame whose stop bit is 0 → no byte accepted, FSM stays in WAIT_A, last_byte unchanged.
- Assert resetk during a TX frame → TX=1 on the next sample; FSM in WAIT_A; the next valid pair computes correctly.
